// File: rtl/ram_bist_ctrl.sv
// Two-pass fill-and-verify RAM BIST engine (pass 0: P^a, pass 1: ~(P^a)).
// Optional: define BIST_STOP_ON_ERR_EN to abort the run on the first mismatch.
module ram_bist_ctrl #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1,
  parameter int ECW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [ECW-1:0] err_cnt,
  output logic [AW-1:0] fail_addr,
  output logic          enb,
  output logic          wr,
  output logic          rd,
  output logic [AW-1:0] w_addr,
  output logic [AW-1:0] r_addr,
  output logic [DW-1:0] w_data,
  input  logic [DW-1:0] r_data
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] e;
    logic [AW-1:0] a;
  } pipe_t;

  localparam logic [AW-1:0] LAST     = '1;
  localparam logic [2:0]    DRN_LAST = 3'(RD_LAT - 1);

  function automatic logic [DW-1:0] exp_fn(input logic [DW-1:0] p,
                                           input logic [AW-1:0] a,
                                           input logic          ph);
    logic [DW-1:0] v;
    v = p ^ DW'(a);
    return ph ? ~v : v;
  endfunction

  state_t          state, state_d;
  logic            pass_idx, pass_idx_d;
  logic [AW-1:0]   addr, addr_d;
  logic [2:0]      drn, drn_d;
  logic [DW-1:0]   pat, pat_d;

  logic            busy_d, done_d, pass_d, enb_d, wr_d, rd_d;
  logic [ECW-1:0]  err_d;
  logic [AW-1:0]   fail_d, w_addr_d, r_addr_d;
  logic [DW-1:0]   w_data_d;

  pipe_t [RD_LAT-1:0] pp;
  pipe_t [RD_LAT:0]   shift_in;
  pipe_t              pin, cmp;
  logic               mism, flush;

  // Stage 0 captures the read presented this cycle; the last stage lines up
  // with r_data RD_LAT cycles after the RAM samples rd/r_addr.
  always_comb begin
    pin.v = rd & ~flush;
    pin.e = exp_fn(pat, r_addr, pass_idx);
    pin.a = r_addr;
  end

  assign shift_in = {pp, pin};
  assign cmp      = pp[RD_LAT-1];
  assign mism     = cmp.v && (r_data != cmp.e);

  always_comb begin
    state_d    = state;
    pass_idx_d = pass_idx;
    addr_d     = addr;
    drn_d      = drn;
    pat_d      = pat;
    busy_d     = busy;
    done_d     = done;
    pass_d     = pass;
    err_d      = err_cnt;
    fail_d     = fail_addr;
    enb_d      = 1'b0;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    w_addr_d   = w_addr;
    r_addr_d   = r_addr;
    w_data_d   = w_data;
    flush      = 1'b0;

    if (mism) begin
      if (err_cnt != '1) err_d = err_cnt + 1'b1;
      if (err_cnt == '0) fail_d = cmp.a;
    end

    case (state)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          pat_d      = pattern;
          err_d      = '0;
          fail_d     = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          pass_idx_d = 1'b0;
          addr_d     = '0;
          state_d    = S_WR;
          enb_d      = 1'b1;
          wr_d       = 1'b1;
          w_addr_d   = '0;
          w_data_d   = exp_fn(pattern, '0, 1'b0);
        end
      end
      S_WR: begin
        if (addr == LAST) begin
          state_d  = S_RD;
          addr_d   = '0;
          enb_d    = 1'b1;
          rd_d     = 1'b1;
          r_addr_d = '0;
        end else begin
          addr_d   = addr + 1'b1;
          enb_d    = 1'b1;
          wr_d     = 1'b1;
          w_addr_d = addr + 1'b1;
          w_data_d = exp_fn(pat, addr + 1'b1, pass_idx);
        end
      end
      S_RD: begin
        if (addr == LAST) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end else begin
          addr_d   = addr + 1'b1;
          enb_d    = 1'b1;
          rd_d     = 1'b1;
          r_addr_d = addr + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drn == DRN_LAST) begin
          if (pass_idx) begin
            // Final compare lands on this edge, so pass uses the updated count.
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            pass_idx_d = 1'b1;
            addr_d     = '0;
            state_d    = S_WR;
            enb_d      = 1'b1;
            wr_d       = 1'b1;
            w_addr_d   = '0;
            w_data_d   = exp_fn(pat, '0, 1'b1);
          end
        end else begin
          drn_d = drn + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef BIST_STOP_ON_ERR_EN
    if (mism) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = 1'b0;
      enb_d   = 1'b0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      flush   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pass_idx  <= 1'b0;
      addr      <= '0;
      drn       <= '0;
      pat       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      enb       <= 1'b0;
      wr        <= 1'b0;
      rd        <= 1'b0;
      w_addr    <= '0;
      r_addr    <= '0;
      w_data    <= '0;
    end else begin
      state     <= state_d;
      pass_idx  <= pass_idx_d;
      addr      <= addr_d;
      drn       <= drn_d;
      pat       <= pat_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_cnt   <= err_d;
      fail_addr <= fail_d;
      enb       <= enb_d;
      wr        <= wr_d;
      rd        <= rd_d;
      w_addr    <= w_addr_d;
      r_addr    <= r_addr_d;
      w_data    <= w_data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pp <= '0;
    else if (flush) pp <= '0;
    else            pp <= shift_in[RD_LAT-1:0];
  end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Initiator-side engine for the single-port-pair RAM interface (enb/wr/rd, separate write and read address, w_data/r_data).
- Runs a two-pass fill-and-verify test over the whole RAM and reports pass/fail, error count and first failing address.
- Sits between the test/boot controller and the RAM, and owns the RAM ports while busy.

Parameters:
- AW, 4: RAM address width; DEPTH = 2**AW.
- DW, 8: RAM data width.
- RD_LAT, 1: cycles from rd/r_addr sampled to r_data valid (1..4).
- ECW, 8: error counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin test; sampled in IDLE only.
- pattern  in  DW  base data pattern; captured on accepted start.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next accepted start.
- pass  out  1  valid while done; 1 = no mismatches.
- err_cnt  out  ECW  mismatch count, saturating.
- fail_addr  out  AW  address of first mismatch; 0 if none.
- enb  out  1  RAM enable.
- wr  out  1  RAM write strobe.
- rd  out  1  RAM read strobe.
- w_addr  out  AW  RAM write address.
- r_addr  out  AW  RAM read address.
- w_data  out  DW  RAM write data.
- r_data  in  DW  RAM read data.

Behaviour:
- Reset (async, any state) clears all of the following and returns to IDLE:
  - busy, done, pass, err_cnt, fail_addr, enb, wr, rd, w_addr, r_addr, w_data, address counter and compare pipeline.
- States: IDLE -> WR -> RD -> DRAIN, repeated for pass 0 and pass 1, then DONE.
- IDLE:
  - On start=1, capture P = pattern, clear err_cnt/fail_addr/done/pass, set busy, go to WR (pass 0).
- Expected data: E(a) = P ^ zero-extend(a) in pass 0, and ~(P ^ zero-extend(a)) in pass 1.
- WR:
  - One write per cycle: enb=1, wr=1, rd=0, w_addr=a, w_data=E(a), for a = 0..DEPTH-1.
  - After a = DEPTH-1, go to RD with a = 0.
- RD:
  - One read per cycle: enb=1, rd=1, wr=0, r_addr=a.
  - A valid bit and E(a)/a enter an RD_LAT-deep shift pipeline.
  - After a = DEPTH-1, go to DRAIN.
- DRAIN:
  - enb=rd=wr=0 for RD_LAT cycles while the pipeline empties.
  - Then go to WR (pass 1), or to DONE after pass 1.
- Compare:
  - When the pipeline output is valid, compare r_data against the expected value.
  - On mismatch, err_cnt increments, saturating at 2**ECW-1.
  - On the first mismatch of the run, fail_addr takes the pipelined address.
- DONE:
  - Registered outputs: busy=0, done=1, pass=(err_cnt==0).
  - Returns to IDLE in the same cycle; done and pass hold until the next accepted start.
- Timing:
  - busy rises on the clock edge that accepts start.
  - busy is high for exactly 2*(2*DEPTH+RD_LAT) cycles.
  - done rises on the edge busy falls.
- Outside WR/RD: enb=wr=rd=0. Addresses and w_data hold their last value.
- wr and rd are never high in the same cycle.
- start while busy: ignored, no restart.
- Address counter wraps DEPTH-1 -> 0 only at state change, never mid-state.
- Reset mid-test: the RAM strobes drop immediately (async), and no done pulse follows.

Optional Feature:
- Macro: BIST_STOP_ON_ERR_EN.
- Defined:
  - The first mismatch aborts the test.
  - Further RAM strobes are suppressed from the next cycle; in-flight compares are discarded.
  - Go to DONE: pass=0, err_cnt=1, fail_addr = failing address.
- Undefined:
  - The full two-pass run always completes and every mismatch is counted.

Test Plan:
- Defaults (AW=4, DW=8, RD_LAT=1), fault-free RAM, pattern=8'hA5, start pulse:
  - busy high for 66 cycles; 16 writes then 16 reads per pass.
  - First pass-0 write: w_addr=0, w_data=8'hA5; pass-1 address 3 writes 8'h59.
  - Result: done=1, pass=1, err_cnt=0, fail_addr=0.
- RAM with bit 0 of address 5 stuck at 0, pattern=8'hA5:
  - Pass 0 expects 8'hA0, so no error; pass 1 expects 8'h5F and reads 8'h5E.
  - Result: err_cnt=1, fail_addr=5, pass=0.
- RAM with every read returning 8'h00, ECW=4:
  - err_cnt saturates at 4'hF, fail_addr=0, pass=0.
- start re-pulsed at cycle 10 of a run:
  - Ignored; total busy is still 66 cycles and the address sequence is unchanged.
- rst asserted mid-RD of pass 0 (asynchronously, between edges):
  - enb/rd/busy go low without waiting for a clock edge; done stays 0.
  - After release, a new start runs a full, clean 66-cycle test.
- With BIST_STOP_ON_ERR_EN and the stuck-at RAM above:
  - Abort in pass 1 after the address-5 read compare, with done=1, pass=0, err_cnt=1, fail_addr=5.
  - No further RAM strobes after the abort.
